seq_signed_divider: RTL and testbench

- Multi-cycle signed divider, the inverse companion of the signed 32x32->64 multiplier.
- Takes a 2W-bit signed dividend, such as a product, and a W-bit signed divisor.
- Returns a W-bit quotient and a W-bit remainder after a radix-2 restoring iteration.
- Truncates toward zero; remainder takes the sign of the dividend.
- Uses a start/busy/done handshake, so it can sit beside the multiplier in the same arithmetic datapath.

---
 rtl/seq_div_pkg.sv | 16 +
 rtl/seq_signed_divider_if.sv | 24 ++
 rtl/div_step.sv | 21 ++
 rtl/seq_signed_divider.sv | 188 ++++++++++++++++++
 tb/tb_seq_signed_divider.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/seq_div_pkg.sv
// Shared types and constants for the sequential signed divider: FSM states, default width,
// and the saturation bounds applied to an out-of-range quotient.
package seq_div_pkg;

  localparam int unsigned DefaultWidth = 32;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFix
  } state_e;

  localparam logic [DefaultWidth-1:0] QMAX = {1'b0, {(DefaultWidth-1){1'b1}}};
  localparam logic [DefaultWidth-1:0] QMIN = {1'b1, {(DefaultWidth-1){1'b0}}};

endpackage

// File: rtl/seq_signed_divider_if.sv
// Start/busy/done handshake and operand/result bundle for the sequential signed divider.
interface seq_signed_divider_if #(
  parameter int unsigned WIDTH = seq_div_pkg::DefaultWidth
);
  logic               start;
  logic [2*WIDTH-1:0] x;
  logic [WIDTH-1:0]   y;
  logic [WIDTH-1:0]   q;
  logic [WIDTH-1:0]   r;
  logic               busy;
  logic               done;
  logic               div_zero;
  logic               ovf;

  modport master (
    output start, x, y,
    input  q, r, busy, done, div_zero, ovf
  );

  modport slave (
    input  start, x, y,
    output q, r, busy, done, div_zero, ovf
  );
endinterface

// File: rtl/div_step.sv
// One combinational radix-2 restoring step: shift in a dividend bit, trial-subtract |divisor|.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] dmag_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // rem_i < |divisor| <= 2^(WIDTH-1), so the shifted value and the trial both fit WIDTH+1 bits.
  always_comb begin
    shifted = {rem_i, bit_i};
    trial   = shifted - {1'b0, dmag_i};
    q_o     = ~trial[WIDTH];
    rem_o   = q_o ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  end
endmodule

// File: rtl/seq_signed_divider.sv
// Multi-cycle signed 2W/W divider, truncating toward zero, with start/busy/done handshake.
// Define SEQ_DIV_FAST_ZERO_EN to finish in one step when |X| < |Y|.
module seq_signed_divider
  import seq_div_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  seq_signed_divider_if.slave  div_io
);
  localparam int unsigned DW   = 2 * WIDTH;
  localparam int unsigned CntW = $clog2(DW + 1);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]     dvd_q, dvd_d;
  logic [WIDTH-1:0]  rem_q, rem_d;
  logic [WIDTH-1:0]  ymag_q, ymag_d;
  logic              sx_q, sx_d, sy_q, sy_d, zero_q, zero_d;
  logic [WIDTH-1:0]  q_q, q_d, r_q, r_d;
  logic              busy_q, busy_d, done_q, done_d, dz_q, dz_d, ovf_q, ovf_d;

  logic [DW-1:0]     xmag;
  logic [WIDTH-1:0]  ymag_in;
  logic              y_zero;
  logic [WIDTH-1:0]  step_rem;
  logic              step_q;
  logic              neg;
  logic [DW-1:0]     lim;
  logic [WIDTH-1:0]  q_mag;

  // Unsigned 2W-bit magnitude: -2^(2W-1) maps to 2^(2W-1) without wrapping.
  assign xmag    = div_io.x[DW-1] ? (~div_io.x + 1'b1) : div_io.x;
  assign ymag_in = div_io.y[WIDTH-1] ? (~div_io.y + 1'b1) : div_io.y;
  assign y_zero  = (div_io.y == '0);

`ifdef SEQ_DIV_FAST_ZERO_EN
  logic x_lt_y;
  assign x_lt_y = (xmag < {{WIDTH{1'b0}}, ymag_in});
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i  (rem_q),
    .bit_i  (dvd_q[DW-1]),
    .dmag_i (ymag_q),
    .rem_o  (step_rem),
    .q_o    (step_q)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (div_io.start) begin
          if (y_zero) begin
            state_d = StFix;
`ifdef SEQ_DIV_FAST_ZERO_EN
          end else if (x_lt_y) begin
            state_d = StFix;
`endif
          end else begin
            state_d = StCalc;
            cnt_d   = CntW'(DW);
          end
        end
      end
      StCalc: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CntW'(1)) state_d = StFix;
      end
      StFix:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Quotient magnitude is the shifted-out dividend register after 2W steps.
  assign neg   = sx_q ^ sy_q;
  assign lim   = {{WIDTH{1'b0}}, neg, {(WIDTH-1){~neg}}};
  assign q_mag = dvd_q[WIDTH-1:0];

  always_comb begin
    dvd_d  = dvd_q;
    rem_d  = rem_q;
    ymag_d = ymag_q;
    sx_d   = sx_q;
    sy_d   = sy_q;
    zero_d = zero_q;
    q_d    = q_q;
    r_d    = r_q;
    busy_d = busy_q;
    done_d = 1'b0;
    dz_d   = dz_q;
    ovf_d  = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (div_io.start) begin
          sx_d   = div_io.x[DW-1];
          sy_d   = div_io.y[WIDTH-1];
          dvd_d  = xmag;
          ymag_d = ymag_in;
          rem_d  = '0;
          zero_d = y_zero;
          busy_d = 1'b1;
          dz_d   = 1'b0;
          ovf_d  = 1'b0;
`ifdef SEQ_DIV_FAST_ZERO_EN
          if (!y_zero && x_lt_y) begin
            rem_d = xmag[WIDTH-1:0];
            dvd_d = '0;
          end
`endif
        end
      end
      StCalc: begin
        rem_d = step_rem;
        dvd_d = {dvd_q[DW-2:0], step_q};
      end
      StFix: begin
        busy_d = 1'b0;
        done_d = 1'b1;
        if (zero_q) begin
          q_d   = '0;
          r_d   = '0;
          dz_d  = 1'b1;
          ovf_d = 1'b0;
        end else if (dvd_q > lim) begin
          q_d   = neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
          r_d   = '0;
          ovf_d = 1'b1;
        end else begin
          q_d = neg ? (~q_mag + 1'b1) : q_mag;
          r_d = sx_q ? (~rem_q + 1'b1) : rem_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dvd_q  <= '0;
      rem_q  <= '0;
      ymag_q <= '0;
      sx_q   <= 1'b0;
      sy_q   <= 1'b0;
      zero_q <= 1'b0;
      q_q    <= '0;
      r_q    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dz_q   <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      dvd_q  <= dvd_d;
      rem_q  <= rem_d;
      ymag_q <= ymag_d;
      sx_q   <= sx_d;
      sy_q   <= sy_d;
      zero_q <= zero_d;
      q_q    <= q_d;
      r_q    <= r_d;
      busy_q <= busy_d;
      done_q <= done_d;
      dz_q   <= dz_d;
      ovf_q  <= ovf_d;
    end
  end

  assign div_io.q        = q_q;
  assign div_io.r        = r_q;
  assign div_io.busy     = busy_q;
  assign div_io.done     = done_q;
  assign div_io.div_zero = dz_q;
  assign div_io.ovf      = ovf_q;

endmodule

// File: tb/tb_seq_signed_divider.sv
// Scoreboard bench for seq_signed_divider: directed and random operands against a wide-integer
// reference model; a monitor pops expectations on every done pulse.
module tb_seq_signed_divider;
  import seq_div_pkg::*;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    logic         ovf;
    int           lat;
    int           e0;
    string        name;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  seq_signed_divider_if #(.WIDTH(W)) dif ();

  seq_signed_divider #(.WIDTH(W)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .div_io (dif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Reference: exact quotient/remainder of the integers, then range-check and saturate.
  function automatic exp_t model(input logic signed [63:0] x, input logic signed [31:0] y,
                                 input string nm);
    exp_t e;
    logic signed [127:0] xw, yw, qw, rw, hi, lo, ax, ay;
    e.name = nm;
    e.e0   = 0;
    e.dz   = 1'b0;
    e.ovf  = 1'b0;
    e.lat  = 65;
    if (y == 0) begin
      e.q   = '0;
      e.r   = '0;
      e.dz  = 1'b1;
      e.lat = 1;
      return e;
    end
    xw = x;
    yw = y;
    hi = 128'sd2147483647;
    lo = -hi - 1;
    qw = xw / yw;
    rw = xw % yw;
    if (qw > hi) begin
      e.ovf = 1'b1; e.q = QMAX; e.r = '0;
    end else if (qw < lo) begin
      e.ovf = 1'b1; e.q = QMIN; e.r = '0;
    end else begin
      e.q = qw[31:0]; e.r = rw[31:0];
    end
    ax = (xw < 0) ? -xw : xw;
    ay = (yw < 0) ? -yw : yw;
`ifdef SEQ_DIV_FAST_ZERO_EN
    if (ax < ay) e.lat = 1;
`else
    if (ax < ay) e.lat = 65;
`endif
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n && dif.done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 required=0");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, ".q"}, 64'(dif.q), 64'(e.q));
        chk({e.name, ".r"}, 64'(dif.r), 64'(e.r));
        chk({e.name, ".div_zero"}, 64'(dif.div_zero), 64'(e.dz));
        chk({e.name, ".ovf"}, 64'(dif.ovf), 64'(e.ovf));
        chk({e.name, ".latency"}, 64'(cyc - e.e0), 64'(e.lat));
        chk({e.name, ".busy_at_done"}, 64'(dif.busy), 64'd0);
      end
    end
  end

  task automatic issue(input logic signed [63:0] x, input logic signed [31:0] y, input string nm);
    exp_t e;
    @(negedge clk);
    dif.start = 1'b1;
    dif.x     = x;
    dif.y     = y;
    @(posedge clk);
    #1;
    e    = model(x, y, nm);
    e.e0 = cyc;
    sb.push_back(e);
    chk({nm, ".busy"}, 64'(dif.busy), 64'd1);
    dif.start = 1'b0;
    dif.x     = {$urandom, $urandom};
    dif.y     = $urandom;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (!dif.done && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!dif.done) begin
      checks++;
      errors++;
      $display("FAIL %s.timeout actual=no_done required=done", nm);
      sb.delete();
    end
  endtask

  task automatic run(input logic signed [63:0] x, input logic signed [31:0] y, input string nm);
    issue(x, y, nm);
    wait_done(nm);
  endtask

  task automatic chk_zero_outputs(input string nm);
    chk({nm, ".q"}, 64'(dif.q), 64'd0);
    chk({nm, ".r"}, 64'(dif.r), 64'd0);
    chk({nm, ".busy"}, 64'(dif.busy), 64'd0);
    chk({nm, ".done"}, 64'(dif.done), 64'd0);
    chk({nm, ".div_zero"}, 64'(dif.div_zero), 64'd0);
    chk({nm, ".ovf"}, 64'(dif.ovf), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    logic signed [63:0] rx;
    logic signed [31:0] ry;
    dif.start = 1'b0;
    dif.x     = '0;
    dif.y     = '0;
    #12;
    chk_zero_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    run(-465, 15, "neg_exact");
    run(100, -7, "pos_by_neg");
    run(-100, 7, "neg_by_pos");
    run(4455, -55, "product");
    run(-300, 0, "div_zero");
    run(64'sh0000_0100_0000_0000, 1, "ovf_pos");
    run(-64'sd2147483648, 1, "qmin_fits");
    run(64'sd2147483648, -1, "qmin_neg");
    run(64'sd2147483648, 1, "ovf_pos_edge");
    run(64'sh8000_0000_0000_0000, -1, "min_by_m1");
    run(64'sh8000_0000_0000_0000, 1, "min_by_1");
    run(64'sh8000_0000_0000_0000, -32'sd2147483648, "min_by_min");
    run(5, -9, "small_x");

    // A start pulse while busy must neither restart nor queue a second operation.
    issue(100, -7, "ignore_start");
    repeat (10) @(negedge clk);
    dif.start = 1'b1;
    dif.x     = 64'sd7;
    dif.y     = 32'sd3;
    @(posedge clk);
    #1;
    dif.start = 1'b0;
    wait_done("ignore_start");

    // Asynchronous reset mid-operation discards the work and clears every output.
    issue(-100, 7, "pre_reset");
    repeat (30) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero_outputs("mid_reset");
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    run(4455, -55, "post_reset");

    // start held high: the second operation is accepted on the edge right after done.
    @(negedge clk);
    dif.start = 1'b1;
    dif.x     = -64'sd1000;
    dif.y     = 32'sd33;
    @(posedge clk);
    #1;
    e    = model(-64'sd1000, 32'sd33, "b2b_first");
    e.e0 = cyc;
    sb.push_back(e);
    dif.x = 64'sd77777;
    dif.y = -32'sd12;
    wait_done("b2b_first");
    @(posedge clk);
    #1;
    e    = model(64'sd77777, -32'sd12, "b2b_second");
    e.e0 = cyc;
    sb.push_back(e);
    dif.start = 1'b0;
    wait_done("b2b_second");

    for (int i = 0; i < 30; i++) begin
      rx = $signed({$urandom, $urandom}) >>> $urandom_range(0, 40);
      ry = $signed($urandom) >>> $urandom_range(0, 28);
      if (i % 7 == 3) ry = 32'sd0;
      run(rx, ry, $sformatf("rand%0d", i));
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
